// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg.sv
// Shared definitions for the power-switch segment sequencer:
// FSM state encoding and the step-counter width helper.
package gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_UP  = 2'd1,
    ST_ON  = 2'd2,
    ST_DN  = 2'd3
  } pwrsw_state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 32'd1;
    for (int unsigned i = 32'd1; i < 32'd31; i++) begin
      if ((32'd1 << i) < n) begin
        w = i + 32'd1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_tmr.sv
// Step timer: free-runs while a ramp is active and pulses once every
// STEP_CYC cycles; clr restarts the interval from zero.
module gf180mcu_fd_sc_mcu9t5v0__pwrsw_tmr #(
  parameter int unsigned STEP_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic step
);
  import gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg::*;

  localparam int unsigned CW   = cnt_width(STEP_CYC);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYC - 32'd1);
  localparam logic [CW-1:0] ONE  = CW'(32'd1);
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};

  logic [CW-1:0] cnt_r;

  assign step = run && (cnt_r == LAST);

  // Interval counter: wraps on the step edge, idles at zero outside ramps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= ZERO;
    end else if (clr) begin
      cnt_r <= ZERO;
    end else if (step) begin
      cnt_r <= ZERO;
    end else if (run) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= ZERO;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
// Power-switch segment sequencer: ramps a thermometer-coded header bank
// on/off one segment per step and reports a settled, fully-on domain.
module gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq #(
  parameter int unsigned N_SEG    = 8,
  parameter int unsigned STEP_CYC = 4,
  parameter bit          FAST_OFF = 1'b0
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  output logic [N_SEG-1:0] SW,
  output logic             ACK,
  output logic             BUSY
);
  import gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg::*;

  localparam logic [N_SEG-1:0] SW_ZERO = {N_SEG{1'b0}};
  localparam logic [N_SEG-1:0] SW_ONE  = N_SEG'(32'd1);
  localparam logic [N_SEG-1:0] SW_FULL = {N_SEG{1'b1}};

  pwrsw_state_e     state_r, state_nx_s;
  logic [N_SEG-1:0] sw_r, sw_nx_s, sw_up_s, sw_dn_s;
  logic             ack_r, busy_r;
  logic             clr_s, run_s, step_s;

  assign sw_up_s = (sw_r << 1'b1) | SW_ONE;
  assign sw_dn_s = sw_r >> 1'b1;
  assign run_s   = (state_r == ST_UP) || (state_r == ST_DN);

  gf180mcu_fd_sc_mcu9t5v0__pwrsw_tmr #(
    .STEP_CYC(STEP_CYC)
  ) u_tmr (
    .clk (CLK),
    .rst (RST),
    .clr (clr_s),
    .run (run_s),
    .step(step_s)
  );

  // Next-state and next-SW: entering UP/DN steps immediately and restarts the timer.
  always_comb begin
    state_nx_s = state_r;
    sw_nx_s    = sw_r;
    clr_s      = 1'b0;
    case (state_r)
      ST_OFF: begin
        if (EN) begin
          state_nx_s = ST_UP;
          sw_nx_s    = sw_up_s;
          clr_s      = 1'b1;
        end else begin
          state_nx_s = ST_OFF;
          sw_nx_s    = SW_ZERO;
        end
      end
      ST_UP: begin
        if (!EN) begin
          if (FAST_OFF) begin
            state_nx_s = ST_OFF;
            sw_nx_s    = SW_ZERO;
          end else begin
            sw_nx_s    = sw_dn_s;
            clr_s      = 1'b1;
            state_nx_s = (sw_dn_s == SW_ZERO) ? ST_OFF : ST_DN;
          end
        end else if (step_s) begin
          // A step that finds the bank full is the settle step.
          if (sw_r == SW_FULL) begin
            state_nx_s = ST_ON;
          end else begin
            sw_nx_s = sw_up_s;
          end
        end else begin
          state_nx_s = ST_UP;
        end
      end
      ST_ON: begin
        if (!EN) begin
          if (FAST_OFF) begin
            state_nx_s = ST_OFF;
            sw_nx_s    = SW_ZERO;
          end else begin
            sw_nx_s    = sw_dn_s;
            clr_s      = 1'b1;
            state_nx_s = (sw_dn_s == SW_ZERO) ? ST_OFF : ST_DN;
          end
        end else begin
          state_nx_s = ST_ON;
        end
      end
      ST_DN: begin
        if (EN) begin
          state_nx_s = ST_UP;
          sw_nx_s    = sw_up_s;
          clr_s      = 1'b1;
        end else if (step_s) begin
          sw_nx_s    = sw_dn_s;
          state_nx_s = (sw_dn_s == SW_ZERO) ? ST_OFF : ST_DN;
        end else begin
          state_nx_s = ST_DN;
        end
      end
      default: begin
        state_nx_s = ST_OFF;
        sw_nx_s    = SW_ZERO;
      end
    endcase
  end

  // State, segment register and status flags, all decoded from the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_OFF;
      sw_r    <= SW_ZERO;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      sw_r    <= sw_nx_s;
      ack_r   <= (state_nx_s == ST_ON);
      busy_r  <= (state_nx_s == ST_UP) || (state_nx_s == ST_DN);
    end
  end

  assign SW   = sw_r;
  assign ACK  = ack_r;
  assign BUSY = busy_r;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
// Scoreboard bench for the power-switch sequencer: three configurations,
// directed ramps with hand-derived expectations plus a random EN run.
module tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, rst2, en0, en1, en2;
  logic [7:0] sw0, sw1;
  logic [0:0] sw2;
  logic       ack0, ack1, ack2, busy0, busy1, busy2;

  gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq #(.N_SEG(8), .STEP_CYC(4), .FAST_OFF(1'b0)) u_dut0 (
    .CLK(clk), .RST(rst0), .EN(en0), .SW(sw0), .ACK(ack0), .BUSY(busy0));
  gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq #(.N_SEG(8), .STEP_CYC(4), .FAST_OFF(1'b1)) u_dut1 (
    .CLK(clk), .RST(rst1), .EN(en1), .SW(sw1), .ACK(ack1), .BUSY(busy1));
  gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq #(.N_SEG(1), .STEP_CYC(1), .FAST_OFF(1'b0)) u_dut2 (
    .CLK(clk), .RST(rst2), .EN(en2), .SW(sw2), .ACK(ack2), .BUSY(busy2));

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] tag;
    logic [7:0]  sw;
    logic        ack;
    logic        busy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void compare(string name, int tag,
                                  logic [7:0] asw, logic aack, logic abusy,
                                  logic [7:0] esw, logic eack, logic ebusy);
    checks++;
    if (asw !== esw || aack !== eack || abusy !== ebusy) begin
      errors++;
      $display("FAIL %s tag=%0d: got sw=%h ack=%b busy=%b, expected sw=%h ack=%b busy=%b",
               name, tag, asw, aack, abusy, esw, eack, ebusy);
    end
  endfunction

  // Expected SW k edges after power-up starts (step every 4 edges, 8 segments).
  function automatic logic [7:0] up_sw(int k);
    if (k >= 28) return 8'hFF;
    return 8'((32'd1 << (k / 4 + 1)) - 32'd1);
  endfunction

  // Expected SW k edges after stepped power-down starts from full.
  function automatic logic [7:0] dn_sw(int k);
    return 8'(32'hFF >> (k / 4 + 1));
  endfunction

  task automatic push_exp(int id, int tag, logic [7:0] sw, logic ack, logic busy);
    exp_t e;
    e.id   = 2'(id);
    e.tag  = 16'(tag);
    e.sw   = sw;
    e.ack  = ack;
    e.busy = busy;
    sbq.push_back(e);
  endtask

  // Drive EN for the next edge and queue the outputs expected after it.
  task automatic drive(int id, logic en, int tag, logic [7:0] sw, logic ack, logic busy);
    @(negedge clk);
    case (id)
      0:       en0 = en;
      1:       en1 = en;
      default: en2 = en;
    endcase
    push_exp(id, tag, sw, ack, busy);
  endtask

  // Monitor: after every active edge, compare one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.id)
          2'd0:    compare("dut0", int'(e.tag), sw0, ack0, busy0, e.sw, e.ack, e.busy);
          2'd1:    compare("dut1", int'(e.tag), sw1, ack1, busy1, e.sw, e.ack, e.busy);
          default: compare("dut2", int'(e.tag), {7'b0, sw2}, ack2, busy2, e.sw, e.ack, e.busy);
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] e, prev, p1, diff;
    logic       en;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    en0 = 1'b0;  en1 = 1'b0;  en2 = 1'b0;
    repeat (2) @(negedge clk);
    compare("reset0", 0, sw0, ack0, busy0, 8'h00, 1'b0, 1'b0);
    compare("reset1", 0, sw1, ack1, busy1, 8'h00, 1'b0, 1'b0);
    compare("reset2", 0, {7'b0, sw2}, ack2, busy2, 8'h00, 1'b0, 1'b0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    for (int k = 0; k < 2; k++) drive(0, 1'b0, 10 + k, 8'h00, 1'b0, 1'b0);

    // Power-up: SW steps every 4 edges, settle step, then ACK.
    for (int k = 0; k <= 32; k++) drive(0, 1'b1, 100 + k, up_sw(k), k == 32, k <= 31);
    for (int k = 33; k <= 35; k++) drive(0, 1'b1, 100 + k, 8'hFF, 1'b1, 1'b0);

    // From ON: start power-down, reverse to UP at k=5, settle again.
    for (int k = 0; k <= 13; k++) begin
      if (k < 5) e = dn_sw(k);
      else if (k < 9) e = 8'h7F;
      else e = 8'hFF;
      drive(0, k >= 5, 200 + k, e, k == 13, k < 13);
    end

    // Stepped power-down to OFF.
    for (int k = 0; k <= 30; k++) drive(0, 1'b0, 300 + k, (k <= 28) ? dn_sw(k) : 8'h00, 1'b0, k < 28);

    // Reversal UP -> DN at k=9 with SW=0x07.
    for (int k = 0; k <= 20; k++) begin
      if (k < 9) e = up_sw(k);
      else if (k < 13) e = 8'h03;
      else if (k < 17) e = 8'h01;
      else e = 8'h00;
      drive(0, k < 9, 400 + k, e, 1'b0, k < 17);
    end

    // Async reset mid-UP, then restart with EN held high.
    for (int k = 0; k <= 13; k++) drive(0, 1'b1, 500 + k, up_sw(k), 1'b0, 1'b1);
    @(negedge clk);
    #1 rst0 = 1'b1;
    #1 compare("async_rst", 599, sw0, ack0, busy0, 8'h00, 1'b0, 1'b0);
    #1 rst0 = 1'b0;
    push_exp(0, 600, 8'h01, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) drive(0, 1'b1, 600 + k, up_sw(k), 1'b0, 1'b1);

    // Random EN toggling: thermometer code, single-bit changes, ACK/BUSY exclusive.
    prev = sw0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) en0 = ~en0;
      @(posedge clk);
      #2;
      p1   = sw0 + 8'd1;
      diff = sw0 ^ prev;
      checks++;
      if ((sw0 & p1) != 8'h00 || (diff & (diff - 8'd1)) != 8'h00 || (ack0 && busy0)) begin
        errors++;
        $display("FAIL random_thermo cycle=%0d: got sw=%h prev=%h ack=%b busy=%b, expected thermometer code with <=1 bit change",
                 i, sw0, prev, ack0, busy0);
      end
      prev = sw0;
    end

    // FAST_OFF: EN low in ON, then in UP with SW=0x0F.
    for (int k = 0; k <= 32; k++) drive(1, 1'b1, 700 + k, up_sw(k), k == 32, k <= 31);
    drive(1, 1'b0, 733, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 734, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k <= 12; k++) drive(1, 1'b1, 800 + k, up_sw(k), 1'b0, 1'b1);
    drive(1, 1'b0, 813, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 814, 8'h00, 1'b0, 1'b0);

    // N_SEG=1, STEP_CYC=1 corners.
    drive(2, 1'b1, 900, 8'h01, 1'b0, 1'b1);
    drive(2, 1'b1, 901, 8'h01, 1'b1, 1'b0);
    drive(2, 1'b1, 902, 8'h01, 1'b1, 1'b0);
    drive(2, 1'b0, 903, 8'h00, 1'b0, 1'b0);
    drive(2, 1'b0, 904, 8'h00, 1'b0, 1'b0);
    drive(2, 1'b1, 905, 8'h01, 1'b0, 1'b1);
    drive(2, 1'b0, 906, 8'h00, 1'b0, 1'b0);
    drive(2, 1'b0, 907, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
